// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg : shared types and MISR step function for the BIST harness
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam logic [9:0] DEFAULT_MISR_POLY = 10'h204;
  localparam int         MISR_MAX_W        = 32;

  // Width-generic step; bits at or above width are forced to zero.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] resp,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] nxt;
    nxt = {sig[MISR_MAX_W-2:0], 1'b0} ^ (sig[width-1] ? poly : '0) ^ resp;
    for (int i = 0; i < MISR_MAX_W; i++) begin
      if (i >= width) nxt[i] = 1'b0;
    end
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/misr_reg.sv
// ---------------------------------------------------------------------------
// misr_reg : multiple-input signature register with seed load and fold enable
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module misr_reg
  import bist_pkg::*;
#(
  parameter int               N_OUT     = 10,
  parameter logic [N_OUT-1:0] MISR_POLY = DEFAULT_MISR_POLY,
  parameter logic [N_OUT-1:0] MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic [N_OUT-1:0] data,
  output logic [N_OUT-1:0] sig,
  output logic [N_OUT-1:0] sig_next
);

  logic [N_OUT-1:0]      r_sig;
  logic [MISR_MAX_W-1:0] w_step;
  logic                  w_unused_hi;

  assign w_step      = misr_step(MISR_MAX_W'(r_sig), MISR_MAX_W'(data),
                                 MISR_MAX_W'(MISR_POLY), N_OUT);
  assign w_unused_hi = ^w_step[MISR_MAX_W-1:N_OUT];

  // Load wins over fold so a restart always begins from the seed.
  always_comb begin
    sig_next = r_sig;
    if (load)        sig_next = MISR_SEED;
    else if (enable) sig_next = w_step[N_OUT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_sig <= MISR_SEED;
    else     r_sig <= sig_next;
  end

  assign sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/bist_harness_7x10.sv
// ---------------------------------------------------------------------------
// bist_harness_7x10 : exhaustive pattern driver and MISR response compactor
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bist_harness_7x10
  import bist_pkg::*;
#(
  parameter int               N_IN       = 7,
  parameter int               N_OUT      = 10,
  parameter int               PIPE_LAT   = 0,
  parameter logic [N_OUT-1:0] MISR_POLY  = DEFAULT_MISR_POLY,
  parameter logic [N_OUT-1:0] MISR_SEED  = '0,
  parameter logic [N_OUT-1:0] GOLDEN_SIG = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  pattern,
  input  logic [N_OUT-1:0] response,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature
);

  localparam logic [N_IN:0] c_pat_one = {{N_IN{1'b0}}, 1'b1};

  bist_state_t      r_state, w_state_nxt;
  logic [N_IN:0]    r_pat_cnt;
  logic             r_pass;
  logic             w_start_ok, w_apply, w_pat_last, w_drain_last, w_fold;
  logic [N_OUT-1:0] w_sig_next;

  assign w_apply    = (r_state == APPLY);
  assign w_pat_last = w_apply && (r_pat_cnt[N_IN-1:0] == {N_IN{1'b1}});

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_state_nxt = APPLY;
        w_start_ok  = 1'b1;
      end
      APPLY:   if (w_pat_last) w_state_nxt = (PIPE_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (w_drain_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) begin
      w_state_nxt = IDLE;
      w_start_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counter steps past the last pattern into the MSB, which then pins the output.
  always_ff @(posedge clk) begin
    if (rst || abort || w_start_ok) r_pat_cnt <= '0;
    else if (w_apply)               r_pat_cnt <= r_pat_cnt + c_pat_one;
  end

  assign pattern = r_pat_cnt[N_IN] ? {N_IN{1'b1}} : r_pat_cnt[N_IN-1:0];

  generate
    if (PIPE_LAT > 0) begin : g_drain
      localparam int              c_dw     = $clog2(PIPE_LAT + 1);
      localparam logic [c_dw-1:0] c_d_one  = c_dw'(1);
      localparam logic [c_dw-1:0] c_d_last = c_dw'(PIPE_LAT - 1);

      logic [c_dw-1:0]     r_drain_cnt;
      logic [PIPE_LAT-1:0] r_vpipe;

      always_ff @(posedge clk) begin
        if (rst || abort || (r_state != DRAIN)) r_drain_cnt <= '0;
        else                                    r_drain_cnt <= r_drain_cnt + c_d_one;
      end

      always_ff @(posedge clk) begin
        if (rst || abort) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe[0] <= w_apply;
          for (int i = 1; i < PIPE_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
      end

      assign w_drain_last = (r_drain_cnt == c_d_last);
      assign w_fold       = r_vpipe[PIPE_LAT-1];
    end else begin : g_no_drain
      assign w_drain_last = 1'b1;
      assign w_fold       = w_apply;
    end
  endgenerate

  misr_reg #(
    .N_OUT     (N_OUT),
    .MISR_POLY (MISR_POLY),
    .MISR_SEED (MISR_SEED)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .load     (w_start_ok),
    .enable   (w_fold && !abort),
    .data     (response),
    .sig      (signature),
    .sig_next (w_sig_next)
  );

  // Judged on the post-fold signature so the final fold is included.
  always_ff @(posedge clk) begin
    if (rst) r_pass <= 1'b0;
    else     r_pass <= (w_state_nxt == DONE) && (w_sig_next == GOLDEN_SIG);
  end

  assign busy = (r_state == APPLY) || (r_state == DRAIN);
  assign done = (r_state == DONE);
  assign pass = r_pass;

endmodule

`default_nettype wire

// File: tb/tb_bist_harness_7x10.sv
// ---------------------------------------------------------------------------
// tb_bist_harness_7x10 : scoreboard bench for three harness configurations
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bist_harness_7x10;

  function automatic logic [9:0] core_fn(input logic [6:0] p);
    logic [2:0] s;
    s = p[6:4] + p[2:0];
    return {p ^ {p[2:0], p[6:3]}, s};
  endfunction

  function automatic logic [9:0] resp_fn(input int mode, input logic [6:0] p);
    case (mode)
      0: return 10'h000;
      1: return (p == 7'd127) ? 10'h001 : 10'h000;
      2: return (p == 7'd126) ? 10'h001 : 10'h000;
      3: return {3'b000, p};
      4: return core_fn(p);
      default: return core_fn(p) ^ ((p == 7'd77) ? 10'h010 : 10'h000);
    endcase
  endfunction

  function automatic logic [9:0] model_sig(input int mode, input logic [9:0] seed);
    logic [9:0] s;
    s = seed;
    for (int p = 0; p < 128; p++)
      s = {s[8:0], 1'b0} ^ (s[9] ? 10'h204 : 10'h000) ^ resp_fn(mode, 7'(p));
    return s;
  endfunction

  localparam logic [9:0] c_seed_c = 10'h2A5;
  localparam logic [9:0] c_golden = model_sig(4, c_seed_c);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [3];
  logic       abort_v [3];
  logic [6:0] pat_v   [3];
  logic [9:0] resp_v  [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [9:0] sig_v   [3];
  int         mode0 = 0;
  logic       flip  = 1'b0;
  logic [6:0] d1 = '0, d2 = '0, d3 = '0;
  logic [9:0] exp_q [$];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  always_comb resp_v[0] = resp_fn(mode0, pat_v[0]);
  always_comb resp_v[1] = {3'b000, d3};
  always_comb resp_v[2] = resp_fn(flip ? 5 : 4, pat_v[2]);

  // Models a three-stage pipelined core in front of the PIPE_LAT=3 harness.
  always @(posedge clk) begin
    d1 <= pat_v[1];
    d2 <= d1;
    d3 <= d2;
  end

  bist_harness_7x10 #(.PIPE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .pattern(pat_v[0]),
    .response(resp_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));

  bist_harness_7x10 #(.PIPE_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .pattern(pat_v[1]),
    .response(resp_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .signature(sig_v[1]));

  bist_harness_7x10 #(.PIPE_LAT(0), .MISR_SEED(c_seed_c), .GOLDEN_SIG(c_golden)) u_dutc (
    .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .pattern(pat_v[2]),
    .response(resp_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .signature(sig_v[2]));

  // Entered and left on a falling edge; n_cyc counts cycles from k+1 until done.
  task automatic run_to_done(input int d, input int restart_at, output int n_busy,
                             output int n_cyc, output bit drain_ok, output bit timeout);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    n_busy = 0; n_cyc = 0; drain_ok = 1'b1; timeout = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (done_v[d]) begin
        timeout = 1'b0;
        break;
      end
      if (busy_v[d]) n_busy++;
      if (n_cyc >= 128 && pat_v[d] != 7'd127) drain_ok = 1'b0;
      start_v[d] = (i == restart_at);
      n_cyc++;
      @(negedge clk);
    end
    start_v[d] = 1'b0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (pat_v[d] !== 7'd0 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || pass_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got pat=%0d busy=%b done=%b pass=%b, want 0/0/0/0",
                 d, pat_v[d], busy_v[d], done_v[d], pass_v[d]);
      end
      checks++;
      if (sig_v[d] !== ((d == 2) ? c_seed_c : 10'h000)) begin
        errors++;
        $display("FAIL reset_sig[%0d]: got %h", d, sig_v[d]);
      end
    end
  endtask

  task automatic test_basic_run(input int mode, input logic [9:0] exp_sig, input logic exp_pass);
    int n_busy, n_cyc; bit dok, to; logic [9:0] e;
    mode0 = mode;
    exp_q.push_back(exp_sig);
    run_to_done(0, -1, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || n_cyc != 128 || n_busy != 128) begin
      errors++;
      $display("FAIL run%0d_timing: got cycles=%0d busy=%0d timeout=%b, want 128/128/0", mode, n_cyc, n_busy, to);
    end
    checks++;
    if (sig_v[0] !== e || pass_v[0] !== exp_pass) begin
      errors++;
      $display("FAIL run%0d_sig: got sig=%h pass=%b, want sig=%h pass=%b", mode, sig_v[0], pass_v[0], e, exp_pass);
    end
  endtask

  task automatic test_pipelined();
    int n_busy, n_cyc; bit dok, to; logic [9:0] e;
    exp_q.push_back(model_sig(3, 10'h000));
    run_to_done(1, -1, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || n_cyc != 131 || n_busy != 131) begin
      errors++;
      $display("FAIL pipe_timing: got cycles=%0d busy=%0d timeout=%b, want 131/131/0", n_cyc, n_busy, to);
    end
    checks++;
    if (!dok) begin
      errors++;
      $display("FAIL pipe_drain_pattern: pattern left 127 during drain, want 127");
    end
    checks++;
    if (sig_v[1] !== e || sig_v[1] !== sig_v[0]) begin
      errors++;
      $display("FAIL pipe_sig: got %h (lat0 run %h), want %h", sig_v[1], sig_v[0], e);
    end
  endtask

  task automatic test_abort();
    int n_busy, n_cyc; bit dok, to; logic [9:0] e;
    bit seen = 1'b0;
    mode0 = 3;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pat_v[0] == 7'd40) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL abort_reach40: pattern never reached 40, want 40");
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pat_v[0] !== 7'd0 || pass_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b pat=%0d pass=%b, want 0/0/0/0",
               busy_v[0], done_v[0], pat_v[0], pass_v[0]);
    end
    exp_q.push_back(model_sig(3, 10'h000));
    run_to_done(0, -1, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || n_cyc != 128 || sig_v[0] !== e) begin
      errors++;
      $display("FAIL abort_restart: got cycles=%0d sig=%h, want 128 sig=%h", n_cyc, sig_v[0], e);
    end
  endtask

  task automatic test_rst_and_busy_start();
    int n_busy, n_cyc; bit dok, to; logic [9:0] e;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (129) @(negedge clk);
    checks++;
    if (busy_v[1] !== 1'b1 || pat_v[1] !== 7'd127) begin
      errors++;
      $display("FAIL drain_entry: got busy=%b pat=%0d, want 1/127", busy_v[1], pat_v[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy_v[1] !== 1'b0 || done_v[1] !== 1'b0 || pat_v[1] !== 7'd0 || sig_v[1] !== 10'h000) begin
      errors++;
      $display("FAIL rst_in_drain: got busy=%b done=%b pat=%0d sig=%h, want 0/0/0/000",
               busy_v[1], done_v[1], pat_v[1], sig_v[1]);
    end
    mode0 = 1;
    exp_q.push_back(10'h001);
    run_to_done(0, 20, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || n_cyc != 128 || sig_v[0] !== e || done_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_while_busy: got cycles=%0d sig=%h done=%b, want 128 sig=%h done=1",
               n_cyc, sig_v[0], done_v[0], e);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (done_v[0] !== 1'b0 || sig_v[0] !== 10'h000 || pat_v[0] !== 7'd0 || pass_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_done: got done=%b sig=%h pat=%0d pass=%b, want 0/000/0/0",
               done_v[0], sig_v[0], pat_v[0], pass_v[0]);
    end
  endtask

  task automatic test_core();
    int n_busy, n_cyc; bit dok, to; logic [9:0] e;
    flip = 1'b0;
    exp_q.push_back(c_golden);
    run_to_done(2, -1, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || sig_v[2] !== e || pass_v[2] !== 1'b1) begin
      errors++;
      $display("FAIL core_pass: got sig=%h pass=%b timeout=%b, want sig=%h pass=1", sig_v[2], pass_v[2], to, e);
    end
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    checks++;
    if (done_v[2] !== 1'b0 || pass_v[2] !== 1'b0 || busy_v[2] !== 1'b1 || sig_v[2] !== c_seed_c) begin
      errors++;
      $display("FAIL restart_from_done: got done=%b pass=%b busy=%b sig=%h, want 0/0/1/%h",
               done_v[2], pass_v[2], busy_v[2], sig_v[2], c_seed_c);
    end
    abort_v[2] = 1'b1;
    @(negedge clk);
    abort_v[2] = 1'b0;
    flip = 1'b1;
    exp_q.push_back(model_sig(5, c_seed_c));
    run_to_done(2, -1, n_busy, n_cyc, dok, to);
    e = exp_q.pop_front();
    checks++;
    if (to || sig_v[2] !== e || pass_v[2] !== 1'b0) begin
      errors++;
      $display("FAIL core_flip: got sig=%h pass=%b timeout=%b, want sig=%h pass=0", sig_v[2], pass_v[2], to, e);
    end
    flip = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0;
      abort_v[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    test_reset();
    test_basic_run(0, 10'h000, 1'b1);
    test_basic_run(1, 10'h001, 1'b0);
    test_basic_run(2, 10'h002, 1'b0);
    test_basic_run(3, model_sig(3, 10'h000), 1'b0);
    test_pipelined();
    test_abort();
    test_rst_and_busy_start();
    test_core();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
